// File: rtl/wb_write_sequencer_if.sv
// Write-back sequencer bus: upstream transaction handshake plus the
// single register-file write port. The sequencer connects through the
// slave modport and the upstream/register-file side through master.
interface wb_write_sequencer_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   dstE;
    logic [W-1:0] valE;
    logic [3:0]   dstM;
    logic [W-1:0] valM;
    logic         rf_we;
    logic [3:0]   rf_addr;
    logic [W-1:0] rf_data;
    logic         busy;

    modport slave (
        input  in_valid, dstE, valE, dstM, valM,
        output in_ready, rf_we, rf_addr, rf_data, busy
    );

    modport master (
        output in_valid, dstE, valE, dstM, valM,
        input  in_ready, rf_we, rf_addr, rf_data, busy
    );
endinterface

// File: rtl/wb_write_sequencer.sv
// Serializes the E and M write-back ports onto one register-file write
// port, E before M. A same-register collision writes only M; register
// RNONE is never written.
// Optional build macro WBSEQ_BACK2BACK_EN: accept the next transaction in
// the final write state of the current one, removing the IDLE bubble.
module wb_write_sequencer #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_write_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;

    state_t       state_q;
    state_t       state_n;
    state_t       first_st;
    logic         needM_q;
    logic [3:0]   dE_q;
    logic [3:0]   dM_q;
    logic [W-1:0] vE_q;
    logic [W-1:0] vM_q;
    logic         accept;
    logic         needE_in;
    logic         needM_in;

    assign accept   = bus.in_valid && bus.in_ready;
    assign needE_in = (bus.dstE != RNONE) && (bus.dstE != bus.dstM);
    assign needM_in = (bus.dstM != RNONE);
    assign first_st = needE_in ? WR_E : (needM_in ? WR_M : IDLE);

    // State register; reset abandons any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            needM_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (accept)
                needM_q <= needM_in;
        end
    end

    // Next state: finish the current transaction, or jump straight to the
    // first write of a newly accepted one (only possible in IDLE unless
    // back-to-back acceptance is enabled).
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    state_n = IDLE;
            WR_E:    state_n = needM_q ? WR_M : IDLE;
            WR_M:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (accept)
            state_n = first_st;
    end

    // Outputs decoded from state only, so in_ready never depends on in_valid.
    always_comb begin
        bus.rf_we = (state_q != IDLE);
        bus.busy  = (state_q != IDLE);
`ifdef WBSEQ_BACK2BACK_EN
        bus.in_ready = (state_q == IDLE) || (state_q == WR_M) ||
                       ((state_q == WR_E) && !needM_q);
`else
        bus.in_ready = (state_q == IDLE);
`endif
    end

    // Transaction capture; upstream values are only looked at on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            dE_q <= bus.dstE;
            vE_q <= bus.valE;
            dM_q <= bus.dstM;
            vM_q <= bus.valM;
        end
    end

    // Write port address/data registered for the upcoming state, so rf_*
    // has no combinational path from the inputs and holds in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_addr <= 4'd0;
            bus.rf_data <= '0;
        end else begin
            unique case (state_n)
                WR_E: begin
                    bus.rf_addr <= accept ? bus.dstE : dE_q;
                    bus.rf_data <= accept ? bus.valE : vE_q;
                end
                WR_M: begin
                    bus.rf_addr <= accept ? bus.dstM : dM_q;
                    bus.rf_data <= accept ? bus.valM : vM_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer: a vector table of single
// transactions plus hand-written reset, stall and back-to-back sequences.
module tb_wb_write_sequencer;
`ifdef WBSEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    wb_write_sequencer_if #(.W(64)) bus ();

    wb_write_sequencer #(.W(64), .RNONE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  dE;
        logic [63:0] vE;
        logic [3:0]  dM;
        logic [63:0] vM;
        int          nw;
        logic [3:0]  a0;
        logic [63:0] d0;
        logic [3:0]  a1;
        logic [63:0] d1;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic scramble();
        bus.dstE = 4'($urandom);
        bus.dstM = 4'($urandom);
        bus.valE = {$urandom, $urandom};
        bus.valM = {$urandom, $urandom};
    endtask

    task automatic offer(input logic [3:0] dE, input logic [63:0] vE,
                         input logic [3:0] dM, input logic [63:0] vM);
        bus.in_valid = 1'b1;
        bus.dstE = dE;
        bus.valE = vE;
        bus.dstM = dM;
        bus.valM = vM;
    endtask

    // Wait until the offered transaction is taken; returns just after that edge.
    task automatic wait_accept(input string nm);
        logic r;
        int   c;
        c = 0;
        r = 1'b0;
        while (!r && c < 20) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            c++;
        end
        if (!r) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no accept within 20 cycles, got 0, required 1", nm);
        end
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic run_vec(input int i, input vec_t v);
        offer(v.dE, v.vE, v.dM, v.vM);
        @(negedge clk);
        chk($sformatf("v%0d ready_at_offer", i), 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble();
        for (int k = 0; k < v.nw; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d w%0d rf_we", i, k), 64'(bus.rf_we), 64'd1);
            chk($sformatf("v%0d w%0d rf_addr", i, k), 64'(bus.rf_addr), 64'(k == 0 ? v.a0 : v.a1));
            chk($sformatf("v%0d w%0d rf_data", i, k), bus.rf_data, (k == 0 ? v.d0 : v.d1));
            chk($sformatf("v%0d w%0d busy", i, k), 64'(bus.busy), 64'd1);
            chk($sformatf("v%0d w%0d in_ready", i, k), 64'(bus.in_ready),
                64'(B2B && (k == v.nw - 1)));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk($sformatf("v%0d done rf_we", i), 64'(bus.rf_we), 64'd0);
        chk($sformatf("v%0d done busy", i), 64'(bus.busy), 64'd0);
        chk($sformatf("v%0d done in_ready", i), 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    logic        we_log   [10];
    logic [3:0]  addr_log [10];
    logic [63:0] data_log [10];

    task automatic log_cycles();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            we_log[c]   = bus.rf_we;
            addr_log[c] = bus.rf_addr;
            data_log[c] = bus.rf_data;
        end
    endtask

    initial begin
        logic        exp_we [8];
        logic [3:0]  exp_a  [8];
        logic [63:0] exp_d  [8];

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        scramble();

        //         dE     vE          dM     vM         nw a0     d0          a1     d1
        tbl[0] = '{4'd2,  64'hAAAA,   4'd7,  64'hBBBB,  2, 4'd2,  64'hAAAA,   4'd7,  64'hBBBB};
        tbl[1] = '{4'd4,  64'h100,    4'd4,  64'h200,   1, 4'd4,  64'h200,    4'd0,  64'h0};
        tbl[2] = '{4'd15, 64'h77,     4'd15, 64'h88,    0, 4'd0,  64'h0,      4'd0,  64'h0};
        tbl[3] = '{4'd15, 64'h99,     4'd9,  64'h5,     1, 4'd9,  64'h5,      4'd0,  64'h0};
        tbl[4] = '{4'd6,  64'h1234,   4'd15, 64'hDEAD,  1, 4'd6,  64'h1234,   4'd0,  64'h0};
        tbl[5] = '{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 4'd14, 64'h8000_0000_0000_0001,
                   2, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd14, 64'h8000_0000_0000_0001};
        tbl[6] = '{4'd14, 64'h1,      4'd14, 64'h2,     1, 4'd14, 64'h2,      4'd0,  64'h0};

        // Reset values before any clock edge.
        #1;
        chk("reset rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset rf_addr", 64'(bus.rf_addr), 64'd0);
        chk("reset rf_data", bus.rf_data, 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(i, tbl[i]);

        // Reset asserted during WR_E of an E+M transaction.
        offer(4'd3, 64'h11, 4'd5, 64'h22);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble();
        @(negedge clk);
        chk("rstmid WR_E rf_we", 64'(bus.rf_we), 64'd1);
        chk("rstmid WR_E rf_addr", 64'(bus.rf_addr), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid async rf_we", 64'(bus.rf_we), 64'd0);
        chk("rstmid async busy", 64'(bus.busy), 64'd0);
        chk("rstmid async in_ready", 64'(bus.in_ready), 64'd1);
        chk("rstmid async rf_addr", 64'(bus.rf_addr), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid after c%0d rf_we", c), 64'(bus.rf_we), 64'd0);
            chk($sformatf("rstmid after c%0d in_ready", c), 64'(bus.in_ready), 64'd1);
        end
        @(posedge clk);
        #1;

        // Stall hold-off: second transaction offered while busy.
        for (int c = 0; c < 8; c++) begin
            exp_we[c] = 1'b0;
            exp_a[c]  = 4'd0;
            exp_d[c]  = 64'd0;
        end
        if (B2B) begin
            exp_we[1] = 1'b1; exp_a[1] = 4'd1; exp_d[1] = 64'hA1;
            exp_we[2] = 1'b1; exp_a[2] = 4'd2; exp_d[2] = 64'hA2;
            exp_we[3] = 1'b1; exp_a[3] = 4'd3; exp_d[3] = 64'hB3;
            exp_we[4] = 1'b1; exp_a[4] = 4'd4; exp_d[4] = 64'hB4;
        end else begin
            exp_we[1] = 1'b1; exp_a[1] = 4'd1; exp_d[1] = 64'hA1;
            exp_we[2] = 1'b1; exp_a[2] = 4'd2; exp_d[2] = 64'hA2;
            exp_we[4] = 1'b1; exp_a[4] = 4'd3; exp_d[4] = 64'hB3;
            exp_we[5] = 1'b1; exp_a[5] = 4'd4; exp_d[5] = 64'hB4;
        end
        offer(4'd1, 64'hA1, 4'd2, 64'hA2);
        fork
            begin
                wait_accept("stall accept A");
                offer(4'd3, 64'hB3, 4'd4, 64'hB4);
                wait_accept("stall accept B");
                bus.in_valid = 1'b0;
                scramble();
            end
            log_cycles();
        join
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("stall c%0d rf_we", c), 64'(we_log[c]), 64'(exp_we[c]));
            if (exp_we[c]) begin
                chk($sformatf("stall c%0d rf_addr", c), 64'(addr_log[c]), 64'(exp_a[c]));
                chk($sformatf("stall c%0d rf_data", c), data_log[c], exp_d[c]);
            end
        end
        @(posedge clk);
        #1;

`ifdef WBSEQ_BACK2BACK_EN
        // Three E+M transactions streamed without an IDLE bubble.
        offer(4'd1, 64'h10, 4'd2, 64'h20);
        fork
            begin
                wait_accept("b2b accept 0");
                offer(4'd3, 64'h30, 4'd4, 64'h40);
                wait_accept("b2b accept 1");
                offer(4'd5, 64'h50, 4'd6, 64'h60);
                wait_accept("b2b accept 2");
                bus.in_valid = 1'b0;
                scramble();
            end
            log_cycles();
        join
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("b2b c%0d rf_we", c), 64'(we_log[c]), 64'd1);
            chk($sformatf("b2b c%0d rf_addr", c), 64'(addr_log[c]), 64'(c));
            chk($sformatf("b2b c%0d rf_data", c), data_log[c], 64'(c * 16));
        end
        chk("b2b c7 rf_we", 64'(we_log[7]), 64'd0);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
